serial_scan_ctrl: RTL and testbench
===================================

SERIAL_SCAN_CTRL -- requirements
Module: serial_scan_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, width of the parallel word scanned per job.
REQ-002 Parameter PAT_W, default 5, pattern length in bits.
REQ-003 Parameter CNT_W, default 4, match-counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  job request, sampled only in IDLE.
REQ-007 data_in  input  DATA_W  word to scan, captured on accepted start.
REQ-008 pattern  input  PAT_W  target sequence, MSB = first bit, captured on accepted start.
REQ-009 overlap  input  1  1 = overlapping detection, 0 = non-overlapping; captured on accepted start.
REQ-010 busy  output  1  high in LOAD, SHIFT and DONE states.
REQ-011 done  output  1  one-cycle pulse in DONE state.
REQ-012 bit_out  output  1  serial bit currently presented to the detector core.
REQ-013 match  output  1  Mealy match flag, combinational from the current bit and history.
REQ-014 match_cnt  output  CNT_W  matches in current/last job.
REQ-015 first_pos  output  clog2(DATA_W)  bit index (0 = MSB) of the last bit of the first match.
REQ-016 first_valid  output  1  high once first_pos holds a valid index for the current/last job.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SHIFT, DONE; IDLE->LOAD on start; LOAD->SHIFT unconditionally; SHIFT->DONE after DATA_W bits; DONE->IDLE unconditionally.
REQ-018 In LOAD the block SHALL clear the detector history and fill count, match_cnt, first_pos and first_valid.
REQ-019 In SHIFT the block SHALL present one bit per cycle, MSB first, on bit_out, with a bit index 0..DATA_W-1.
REQ-020 match SHALL be 1 in a SHIFT cycle iff fill count >= PAT_W-1 and {history, bit_out} == pattern; match SHALL be 0 outside SHIFT.
REQ-021 History SHALL shift in bit_out each SHIFT cycle; fill count SHALL increment and saturate at PAT_W-1.
REQ-022 With overlap=0, a match SHALL reset fill count to 0 at that edge, so no bit is shared between matches.
REQ-023 match_cnt SHALL increment on each match and saturate at 2^CNT_W-1.
REQ-024 On the first match of a job, first_pos SHALL capture the bit index and first_valid SHALL set; later matches leave both unchanged.
REQ-025 Latency: start sampled at edge k -> done high in the cycle after edge k+DATA_W+1; busy low from edge k+DATA_W+2.
REQ-026 start while busy SHALL be ignored; no queuing.
REQ-027 Changing data_in, pattern or overlap after acceptance SHALL NOT affect the running job.
REQ-028 match_cnt, first_pos and first_valid SHALL hold their values in DONE and IDLE until the next LOAD.

Reset
REQ-029 rst low SHALL immediately force state IDLE and busy, done, bit_out, match, match_cnt, first_pos, first_valid to 0; history and fill count SHALL clear.
REQ-030 Reset mid-job SHALL abort the job without a done pulse; after release, the next start runs a clean job.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration and the default DATA_W/PAT_W/CNT_W constants.
REQ-032 The detector SHALL be one sub-module, pat_det_core (history, fill count, match, overlap clear, sync clear from LOAD); serial_scan_ctrl holds the FSM, shift register, bit index, counter and first-position capture.

Verification
REQ-033 data_in=16'hDB60, pattern=5'b11011, overlap=1 -> match_cnt=3, first_pos=4, first_valid=1, done exactly one cycle.
REQ-034 Same data and pattern, overlap=0 -> match_cnt=2 (matches at indices 4 and 10), first_pos=4.
REQ-035 data_in=16'h0000, pattern=5'b00000 -> overlap=1: match_cnt=12; overlap=0: match_cnt=3 (indices 4, 9, 14).
REQ-036 data_in=16'hFFFF, pattern=5'b11011 -> match_cnt=0, first_valid=0, done still pulses at the REQ-025 latency.
REQ-037 DATA_W=32, data_in=0, pattern=0, overlap=1 -> match_cnt saturates at 15.
REQ-038 rst low during SHIFT with start held high throughout -> all outputs 0 immediately, no done pulse; after release the next job repeats REQ-033 results; start pulses while busy do not change results.

Source files
------------

// File: rtl/serial_scan_ctrl_pkg.sv
// Shared definitions for the serial pattern-scan controller.
// Default geometry and controller state encoding.
package serial_scan_ctrl_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_PAT_W  = 5;
    localparam int unsigned DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/serial_scan_ctrl_if.sv
// Job request / result bundle for serial_scan_ctrl.
// Master issues jobs; slave is the scan controller.
interface serial_scan_ctrl_if
    import serial_scan_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PAT_W  = DEF_PAT_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
);
    localparam int unsigned POS_W = $clog2(DATA_W);

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic [PAT_W-1:0]  pattern;
    logic              overlap;
    logic              busy;
    logic              done;
    logic              bit_out;
    logic              match;
    logic [CNT_W-1:0]  match_cnt;
    logic [POS_W-1:0]  first_pos;
    logic              first_valid;

    modport master (
        output start, data_in, pattern, overlap,
        input  busy, done, bit_out, match, match_cnt, first_pos, first_valid
    );

    modport slave (
        input  start, data_in, pattern, overlap,
        output busy, done, bit_out, match, match_cnt, first_pos, first_valid
    );

endinterface

// File: rtl/serial_scan_ctrl_pat_det_core.sv
// Serial pattern detector: history shift register, fill counter and Mealy match.
// Non-overlapping mode restarts the fill count on a match so no bit is reused.
module pat_det_core #(
    parameter int unsigned PAT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);
    localparam int unsigned FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;

    assign window = {hist, bit_in};
    assign match  = en && (fill >= FULL) && (window == pattern);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= window[PAT_W-2:0];
            if (match && !overlap)
                fill <= '0;
            else if (fill < FULL)
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/serial_scan_ctrl.sv
// Serial scan controller: loads a word, streams it MSB first into pat_det_core,
// counts matches and records where the first one ended.
module serial_scan_ctrl
    import serial_scan_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PAT_W  = DEF_PAT_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    serial_scan_ctrl_if.slave  bus
);
    localparam int unsigned POS_W = $clog2(DATA_W);
    localparam logic [POS_W-1:0] LAST_IDX = POS_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    scan_state_t       state, state_nxt;
    logic [DATA_W-1:0] sreg;
    logic [PAT_W-1:0]  pat_q;
    logic              ovl_q;
    logic [POS_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [POS_W-1:0]  fpos;
    logic              fvalid;
    logic              accept, load, shift, busy_c, done_c;
    logic              serial_bit, hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b1;
        done_c    = 1'b0;
        accept    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (idx == LAST_IDX)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Job operands are latched at acceptance so later input changes cannot disturb the scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg   <= '0;
            pat_q  <= '0;
            ovl_q  <= 1'b0;
            idx    <= '0;
            cnt    <= '0;
            fpos   <= '0;
            fvalid <= 1'b0;
        end else begin
            if (accept) begin
                sreg  <= bus.data_in;
                pat_q <= bus.pattern;
                ovl_q <= bus.overlap;
            end
            if (load) begin
                idx    <= '0;
                cnt    <= '0;
                fpos   <= '0;
                fvalid <= 1'b0;
            end
            if (shift) begin
                sreg <= {sreg[DATA_W-2:0], 1'b0};
                idx  <= idx + 1'b1;
                if (hit) begin
                    if (cnt != CNT_MAX)
                        cnt <= cnt + 1'b1;
                    if (!fvalid) begin
                        fpos   <= idx;
                        fvalid <= 1'b1;
                    end
                end
            end
        end
    end

    assign serial_bit = shift & sreg[DATA_W-1];

    pat_det_core #(
        .PAT_W (PAT_W)
    ) u_det (
        .clk     (clk),
        .rst_n   (rst),
        .clr     (load),
        .en      (shift),
        .bit_in  (serial_bit),
        .pattern (pat_q),
        .overlap (ovl_q),
        .match   (hit)
    );

    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.bit_out     = serial_bit;
    assign bus.match       = hit;
    assign bus.match_cnt   = cnt;
    assign bus.first_pos   = fpos;
    assign bus.first_valid = fvalid;

endmodule

// File: tb/tb_serial_scan_ctrl.sv
// Self-checking bench for serial_scan_ctrl: vector table, random jobs with a
// reference model, mid-job reset abort and a 32-bit saturation run.
module tb_serial_scan_ctrl;
    import serial_scan_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_scan_ctrl_if #(.DATA_W(16), .PAT_W(5), .CNT_W(4)) bus16 ();
    serial_scan_ctrl_if #(.DATA_W(32), .PAT_W(5), .CNT_W(4)) bus32 ();

    serial_scan_ctrl #(.DATA_W(16), .PAT_W(5), .CNT_W(4)) dut16 (
        .clk (clk), .rst (rst), .bus (bus16.slave)
    );
    serial_scan_ctrl #(.DATA_W(32), .PAT_W(5), .CNT_W(4)) dut32 (
        .clk (clk), .rst (rst), .bus (bus32.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  pat;
        logic        ovl;
        int          cnt;
        int          first;
        logic        fv;
    } vec_t;

    typedef struct {
        int       raw;
        int       cnt;
        int       first;
        logic     fv;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Window ending at bit i (0 = MSB) matches if it equals the pattern and, when
    // non-overlapping, starts after the end of the previously counted match.
    function automatic exp_t model(input logic [15:0] d, input logic [4:0] p, input logic o);
        exp_t r;
        int last;
        logic [4:0] w;
        r.raw = 0; r.first = 0; r.fv = 1'b0;
        last = -1;
        for (int i = 4; i < 16; i++) begin
            for (int j = 0; j < 5; j++)
                w[4-j] = d[15-(i-4+j)];
            if (w == p && (o || (i - 4) > last)) begin
                r.raw++;
                if (!r.fv) begin
                    r.first = i;
                    r.fv    = 1'b1;
                end
                last = i;
            end
        end
        r.cnt = (r.raw > 15) ? 15 : r.raw;
        return r;
    endfunction

    task automatic run_job(input logic [15:0] d, input logic [4:0] p, input logic o, input exp_t e);
        int done_seen  = 0;
        int timing_err = 0;
        int bit_err    = 0;
        int match_seen = 0;
        exp_t x;
        @(negedge clk);
        bus16.start   = 1'b1;
        bus16.data_in = d;
        bus16.pattern = p;
        bus16.overlap = o;
        sb.push_back(e);
        @(posedge clk);
        for (int n = 0; n <= 18; n++) begin
            @(negedge clk);
            if (bus16.busy !== (n <= 17) || bus16.done !== (n == 17))
                timing_err++;
            if (n >= 1 && n <= 16) begin
                if (bus16.bit_out !== d[16-n]) bit_err++;
            end else if (bus16.bit_out !== 1'b0) begin
                bit_err++;
            end
            if (bus16.match === 1'b1)
                match_seen++;
            if (bus16.done === 1'b1) begin
                done_seen++;
                check("sb_not_empty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    x = sb.pop_front();
                    check("match_cnt", bus16.match_cnt, x.cnt);
                    check("first_pos", bus16.first_pos, x.first);
                    check("first_valid", bus16.first_valid, x.fv);
                    check("match_pulses", match_seen, x.raw);
                end
            end
            if (n == 18)
                check("hold_cnt_idle", {bus16.match_cnt, bus16.first_pos, bus16.first_valid},
                      {e.cnt[3:0], e.first[3:0], e.fv});
            // Busy-time noise: ignored starts and changing operands
            if (n < 16) begin
                bus16.start   = 1'($urandom_range(0, 1));
                bus16.data_in = 16'($urandom);
                bus16.pattern = 5'($urandom);
                bus16.overlap = 1'($urandom);
            end else begin
                bus16.start = 1'b0;
            end
        end
        check("busy_done_timing", timing_err, 0);
        check("bit_stream", bit_err, 0);
        check("done_pulses", done_seen, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t  vecs[8];
        exp_t  e;
        logic [15:0] d;
        logic [4:0]  p;
        logic        o;
        int          s;
        int          aborts;
        bit          got32;

        vecs[0] = '{16'hDB60, 5'b11011, 1'b1, 3, 4, 1'b1};
        vecs[1] = '{16'hDB60, 5'b11011, 1'b0, 2, 4, 1'b1};
        vecs[2] = '{16'h0000, 5'b00000, 1'b1, 12, 4, 1'b1};
        vecs[3] = '{16'h0000, 5'b00000, 1'b0, 3, 4, 1'b1};
        vecs[4] = '{16'hFFFF, 5'b11011, 1'b1, 0, 0, 1'b0};
        vecs[5] = '{16'hAAAA, 5'b10101, 1'b1, 6, 4, 1'b1};
        vecs[6] = '{16'hAAAA, 5'b10101, 1'b0, 2, 4, 1'b1};
        vecs[7] = '{16'hFFFF, 5'b11011, 1'b0, 0, 0, 1'b0};

        bus16.start = 1'b0; bus16.data_in = '0; bus16.pattern = '0; bus16.overlap = 1'b0;
        bus32.start = 1'b0; bus32.data_in = '0; bus32.pattern = '0; bus32.overlap = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {bus16.busy, bus16.done, bus16.bit_out, bus16.match,
                              bus16.match_cnt, bus16.first_pos, bus16.first_valid}, 0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            e.raw = vecs[i].cnt; e.cnt = vecs[i].cnt;
            e.first = vecs[i].first; e.fv = vecs[i].fv;
            run_job(vecs[i].data, vecs[i].pat, vecs[i].ovl, e);
        end

        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            s = $urandom_range(0, 11);
            p = (i % 3 == 2) ? 5'($urandom) : d[15-s -: 5];
            o = 1'($urandom);
            run_job(d, p, o, model(d, p, o));
        end

        // Reset in the middle of SHIFT with start held high
        @(negedge clk);
        bus16.start = 1'b1; bus16.data_in = 16'hDB60; bus16.pattern = 5'b11011; bus16.overlap = 1'b1;
        repeat (8) @(negedge clk);
        check("busy_before_abort", bus16.busy, 1);
        rst = 1'b0;
        #1;
        check("abort_outputs_zero", {bus16.busy, bus16.done, bus16.bit_out, bus16.match,
                                     bus16.match_cnt, bus16.first_pos, bus16.first_valid}, 0);
        aborts = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus16.done !== 1'b0 || bus16.busy !== 1'b0) aborts++;
        end
        bus16.start = 1'b0;
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus16.done !== 1'b0) aborts++;
        end
        check("no_done_after_abort", aborts, 0);
        e.raw = 3; e.cnt = 3; e.first = 4; e.fv = 1'b1;
        run_job(16'hDB60, 5'b11011, 1'b1, e);

        // 32-bit instance: counter saturation
        @(negedge clk);
        bus32.start = 1'b1; bus32.data_in = '0; bus32.pattern = '0; bus32.overlap = 1'b1;
        @(negedge clk);
        bus32.start = 1'b0;
        got32 = 1'b0;
        for (int n = 0; n < 60 && !got32; n++) begin
            @(negedge clk);
            if (bus32.done === 1'b1) begin
                got32 = 1'b1;
                check("sat32_cnt", bus32.match_cnt, 15);
                check("sat32_first_pos", bus32.first_pos, 4);
                check("sat32_first_valid", bus32.first_valid, 1);
            end
        end
        check("sat32_done_seen", got32, 1);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
